decode_execute_pipe_reg: RTL
============================

// Module: decode_execute_pipe_reg
// PURPOSE
//  Decode->execute pipeline register with operand bypass muxing, for the 5-stage stall/bypass core.
//  Consumes the stall and bypass-select outputs of the stall/bypass control unit.
//  Per operand, selects the register-file, execute, memory or writeback value, then latches it with the decode fields.
//  Inserts a bubble on stall or flush, and keeps saturating stall/flush event counters.
// PARAMETERS
//  DATA_WIDTH     32  width of operand/result data
//  ADDRESS_BITS   20  width of PC
//  COUNTER_WIDTH  32  width of each event counter
// PORTS
//  clock               in   1             core clock
//  reset               in   1             synchronous, active-high
//  stall               in   1             stall request from the stall/bypass control unit
//  flush               in   1             branch/jump redirect resolved; kill decode instr
//  rs1_data_bypass     in   2             rs1 source select (encoding below)
//  rs2_data_bypass     in   2             rs2 source select
//  rs1_data_decode     in   DATA_WIDTH    register-file read port 1
//  rs2_data_decode     in   DATA_WIDTH    register-file read port 2
//  alu_result_execute  in   DATA_WIDTH    result currently in execute
//  result_memory       in   DATA_WIDTH    result currently in memory stage
//  result_writeback    in   DATA_WIDTH    value being written back
//  pc_decode           in   ADDRESS_BITS  PC of decode instr
//  imm_decode          in   DATA_WIDTH    sign-extended immediate
//  opcode_decode       in   7             opcode
//  funct3_decode       in   3             funct3
//  funct7_decode       in   7             funct7
//  rd_decode           in   5             destination register
//  regwrite_decode     in   1             instr writes rd
//  valid_decode        in   1             decode slot holds a real instr
//  pc_execute..valid_execute  out  (same widths)  registered copies of above decode fields
//  rs1_data_execute    out  DATA_WIDTH    registered bypassed rs1 operand
//  rs2_data_execute    out  DATA_WIDTH    registered bypassed rs2 operand
//  stall_cycles        out  COUNTER_WIDTH cycles in which a bubble was inserted for stall
//  flush_cycles        out  COUNTER_WIDTH cycles in which a bubble was inserted for flush
// BEHAVIOUR
//  Bypass select: 00 reg file, 01 alu_result_execute, 10 result_memory, 11 result_writeback.
//  Operand muxing is combinational; the register adds 1-cycle latency decode->execute.
//  Priority each posedge: reset > flush > stall > normal load.
//  Reset:
//   - all data/pc/imm/funct outputs = 0
//   - opcode_execute = NOP_OPCODE (7'b0010011), rd_execute = 0
//   - regwrite_execute = 0, valid_execute = 0
//   - both counters = 0
//  Bubble (flush or stall):
//   - outputs take the reset values above, except the counters
//   - the opcode is NOT held, so a load never re-triggers its own load-use stall
//  Normal: all decode fields and the bypassed operands are latched.
//  stall held N consecutive cycles -> N bubbles; decode-side hold is upstream's job.
//  flush and stall together -> one bubble; flush_cycles increments, stall_cycles does not.
//  Counters:
//   - increment by 1 per bubble cycle, saturate at all-ones, never wrap
//   - cleared only by reset
//  Reset asserted mid-stall: next cycle outputs are reset values; counters are 0.
//  rd_decode==0 with regwrite_decode=1 is latched as-is; x0 suppression lies in the register file.
// STRUCTURE
//  Shared header pipeline_defs.vh: NOP_OPCODE, LOAD opcode, BYPASS_{REGFILE,EXECUTE,MEMORY,WRITEBACK} encodings.
//  Sub-module operand_bypass_mux (4:1, DATA_WIDTH): instantiated twice, rs1 and rs2.
//  Counters: one saturating-increment always block per counter; no further hierarchy.
// TESTING
//  1. Reset on 3 cycles, then release:
//     - opcode_execute=7'h13, valid/regwrite=0, counters=0
//  2. Normal load, sel=00, rs1_data_decode=32'hA5A5_0001, pc=20'h00104:
//     - next cycle rs1_data_execute=32'hA5A5_0001, pc_execute=20'h00104, valid=1
//  3. Bypass sweep, sources exec=1, mem=2, wb=3, rf=4:
//     - rs1 sel 01/10/11/00 -> rs1_data_execute 1/2/3/4
//     - rs2 independently sel 11 -> 3
//  4. Load-use: stall=1 for 2 cycles with opcode_decode=LOAD:
//     - 2 bubbles: regwrite=0, opcode=NOP
//     - stall_cycles=2; third cycle latches the instr
//  5. flush=1 and stall=1 together for 1 cycle:
//     - 1 bubble, flush_cycles=1, stall_cycles unchanged
//  6. COUNTER_WIDTH=4, stall held 20 cycles:
//     - stall_cycles reaches 4'hF and holds
//     - then reset -> 0

Source files
------------

// File: rtl/decode_execute_pipe_reg_pkg.sv
// Shared pipeline definitions for the decode->execute register: opcode
// constants and the encoding of the operand bypass selects.
package decode_execute_pipe_reg_pkg;

    // ADDI x0, x0, 0 opcode: the canonical bubble
    localparam logic [6:0] NOP_OPCODE  = 7'b0010011;
    // Load opcode; a load in decode is what triggers a load-use stall
    localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

    typedef logic [1:0] bypass_sel_t;

    localparam bypass_sel_t BYPASS_REGFILE   = 2'b00;
    localparam bypass_sel_t BYPASS_EXECUTE   = 2'b01;
    localparam bypass_sel_t BYPASS_MEMORY    = 2'b10;
    localparam bypass_sel_t BYPASS_WRITEBACK = 2'b11;

endpackage

// File: rtl/decode_execute_pipe_reg_operand_bypass_mux.sv
// 4:1 operand source select: register file, or a newer in-flight result
// from execute, memory or writeback.
module operand_bypass_mux
    import decode_execute_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            select,
    input  logic [DATA_WIDTH-1:0] regfile_data,
    input  logic [DATA_WIDTH-1:0] execute_data,
    input  logic [DATA_WIDTH-1:0] memory_data,
    input  logic [DATA_WIDTH-1:0] writeback_data,
    output logic [DATA_WIDTH-1:0] operand
);

    // Pure combinational select; the latency comes from the pipe register
    always_comb begin
        operand = regfile_data;
        case (select)
            BYPASS_REGFILE:   operand = regfile_data;
            BYPASS_EXECUTE:   operand = execute_data;
            BYPASS_MEMORY:    operand = memory_data;
            BYPASS_WRITEBACK: operand = writeback_data;
            default:          operand = regfile_data;
        endcase
    end

endmodule

// File: rtl/decode_execute_pipe_reg.sv
// Decode->execute pipeline register. Bypassed operands are selected
// combinationally and latched with the decode fields. A stall or flush
// loads a bubble (NOP, not valid, no regwrite) rather than holding the
// instruction, so a load can never re-trigger its own load-use stall.
// Holding the decode side during a stall is upstream's job.
// Saturating counters record how many bubbles came from stalls and flushes;
// when both are requested together the bubble is charged to flush only.
module decode_execute_pipe_reg
    import decode_execute_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_BITS  = 20,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [1:0]               rs1_data_bypass,
    input  logic [1:0]               rs2_data_bypass,
    input  logic [DATA_WIDTH-1:0]    rs1_data_decode,
    input  logic [DATA_WIDTH-1:0]    rs2_data_decode,
    input  logic [DATA_WIDTH-1:0]    alu_result_execute,
    input  logic [DATA_WIDTH-1:0]    result_memory,
    input  logic [DATA_WIDTH-1:0]    result_writeback,
    input  logic [ADDRESS_BITS-1:0]  pc_decode,
    input  logic [DATA_WIDTH-1:0]    imm_decode,
    input  logic [6:0]               opcode_decode,
    input  logic [2:0]               funct3_decode,
    input  logic [6:0]               funct7_decode,
    input  logic [4:0]               rd_decode,
    input  logic                     regwrite_decode,
    input  logic                     valid_decode,
    output logic [ADDRESS_BITS-1:0]  pc_execute,
    output logic [DATA_WIDTH-1:0]    imm_execute,
    output logic [6:0]               opcode_execute,
    output logic [2:0]               funct3_execute,
    output logic [6:0]               funct7_execute,
    output logic [4:0]               rd_execute,
    output logic                     regwrite_execute,
    output logic                     valid_execute,
    output logic [DATA_WIDTH-1:0]    rs1_data_execute,
    output logic [DATA_WIDTH-1:0]    rs2_data_execute,
    output logic [COUNTER_WIDTH-1:0] stall_cycles,
    output logic [COUNTER_WIDTH-1:0] flush_cycles
);

    logic [DATA_WIDTH-1:0] rs1_operand;
    logic [DATA_WIDTH-1:0] rs2_operand;
    logic                  bubble;

    assign bubble = flush | stall;

    operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH)) rs1_mux (
        .select         (rs1_data_bypass),
        .regfile_data   (rs1_data_decode),
        .execute_data   (alu_result_execute),
        .memory_data    (result_memory),
        .writeback_data (result_writeback),
        .operand        (rs1_operand)
    );

    operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH)) rs2_mux (
        .select         (rs2_data_bypass),
        .regfile_data   (rs2_data_decode),
        .execute_data   (alu_result_execute),
        .memory_data    (result_memory),
        .writeback_data (result_writeback),
        .operand        (rs2_operand)
    );

    // Pipe register: reset and bubble both load the NOP pattern, else latch decode
    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            pc_execute       <= '0;
            imm_execute      <= '0;
            opcode_execute   <= NOP_OPCODE;
            funct3_execute   <= '0;
            funct7_execute   <= '0;
            rd_execute       <= '0;
            regwrite_execute <= 1'b0;
            valid_execute    <= 1'b0;
            rs1_data_execute <= '0;
            rs2_data_execute <= '0;
        end else begin
            pc_execute       <= pc_decode;
            imm_execute      <= imm_decode;
            opcode_execute   <= opcode_decode;
            funct3_execute   <= funct3_decode;
            funct7_execute   <= funct7_decode;
            rd_execute       <= rd_decode;
            regwrite_execute <= regwrite_decode;
            valid_execute    <= valid_decode;
            rs1_data_execute <= rs1_operand;
            rs2_data_execute <= rs2_operand;
        end
    end

    // Stall bubble counter: only stalls not overridden by a flush, saturating
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + COUNTER_WIDTH'(1);
        end
    end

    // Flush bubble counter: every flush cycle, saturating
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cycles <= '0;
        end else if (flush && (flush_cycles != '1)) begin
            flush_cycles <= flush_cycles + COUNTER_WIDTH'(1);
        end
    end

endmodule
